// File: rtl/exe_wb_pipe.sv
// EXE->WB pipeline register: DEPTH stages of {valid, wen, waddr, data} with
// stall/flush control, youngest-first forwarding and a saturating commit counter.
module exe_wb_pipe #(
  parameter int DSIZE    = 16,
  parameter int ASIZE    = 3,
  parameter int DEPTH    = 1,
  parameter int ZERO_REG = 1,
  parameter int CNTW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_wen,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             stall,
  input  logic             flush,
  output logic [DSIZE-1:0] aluout_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             valid_out,
  output logic             wb_en,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [DSIZE-1:0] fwd_data1,
  output logic [DSIZE-1:0] fwd_data2,
  output logic [CNTW-1:0]  commit_cnt
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] w_q;
  logic [ASIZE-1:0] a_q [DEPTH];
  logic [DSIZE-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      w_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      w_q[0] <= in_wen;
      a_q[0] <= waddr_in;
      d_q[0] <= aluout_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        w_q[i] <= w_q[i-1];
        a_q[i] <= a_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  always_comb begin
    eff = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      eff[i] = v_q[i] & w_q[i] & ~((ZERO_REG != 0) && (a_q[i] == '0));
  end

  assign aluout_out = d_q[DEPTH-1];
  assign waddr_out  = a_q[DEPTH-1];
  assign valid_out  = v_q[DEPTH-1];
  assign wb_en      = eff[DEPTH-1] & ~stall;

  // Ascending search with a sticky hit flag so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!fwd_hit1 && eff[i] && (a_q[i] == raddr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = d_q[i];
      end
      if (!fwd_hit2 && eff[i] && (a_q[i] == raddr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = d_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      commit_cnt <= '0;
    else if (wb_en && (commit_cnt != '1))
      commit_cnt <= commit_cnt + 1'b1;
  end

endmodule

// File: tb/tb_exe_wb_pipe.sv
// Bench for exe_wb_pipe: a DEPTH=1 and a DEPTH=3/CNTW=4 instance share stimulus;
// per-instance scoreboards check the output stream, directed checks cover the rest.
module tb_exe_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_wen, stall, flush;
  logic [15:0] aluout_in;
  logic [2:0]  waddr_in, raddr1, raddr2;

  logic [15:0] ao1, fd1a, fd1b, ao3, fd3a, fd3b;
  logic [2:0]  wa1, wa3;
  logic        vo1, wb1, fh1a, fh1b, vo3, wb3, fh3a, fh3b;
  logic [15:0] cnt1;
  logic [3:0]  cnt3;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  exe_wb_pipe #(.DSIZE(16), .ASIZE(3), .DEPTH(1), .ZERO_REG(1), .CNTW(16)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wen(in_wen),
    .aluout_in(aluout_in), .waddr_in(waddr_in), .stall(stall), .flush(flush),
    .aluout_out(ao1), .waddr_out(wa1), .valid_out(vo1), .wb_en(wb1),
    .raddr1(raddr1), .raddr2(raddr2), .fwd_hit1(fh1a), .fwd_hit2(fh1b),
    .fwd_data1(fd1a), .fwd_data2(fd1b), .commit_cnt(cnt1)
  );

  exe_wb_pipe #(.DSIZE(16), .ASIZE(3), .DEPTH(3), .ZERO_REG(1), .CNTW(4)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wen(in_wen),
    .aluout_in(aluout_in), .waddr_in(waddr_in), .stall(stall), .flush(flush),
    .aluout_out(ao3), .waddr_out(wa3), .valid_out(vo3), .wb_en(wb3),
    .raddr1(raddr1), .raddr2(raddr2), .fwd_hit1(fh3a), .fwd_hit2(fh3b),
    .fwd_data1(fd3a), .fwd_data2(fd3b), .commit_cnt(cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: an entry leaves stage DEPTH-1 whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (!rst && vo1 && !stall) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d1_spurious_out: got addr %0h data %0h expected nothing", wa1, ao1);
      end else begin
        e1 = q1.pop_front();
        chk("d1_waddr", 32'(wa1), 32'(e1.a));
        chk("d1_data", 32'(ao1), 32'(e1.d));
        chk("d1_wb_en", 32'(wb1), 32'(e1.e));
      end
    end else if (!rst && vo1 && stall) begin
      chk("d1_wb_en_stalled", 32'(wb1), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (!rst && vo3 && !stall) begin
      if (q3.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d3_spurious_out: got addr %0h data %0h expected nothing", wa3, ao3);
      end else begin
        e3 = q3.pop_front();
        chk("d3_waddr", 32'(wa3), 32'(e3.a));
        chk("d3_data", 32'(ao3), 32'(e3.d));
        chk("d3_wb_en", 32'(wb3), 32'(e3.e));
      end
    end else if (!rst && vo3 && stall) begin
      chk("d3_wb_en_stalled", 32'(wb3), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic w, input logic [2:0] a, input logic [15:0] d);
    exp_t x;
    in_valid  = v;
    in_wen    = w;
    waddr_in  = a;
    aluout_in = d;
    x.a = a;
    x.d = d;
    x.e = w && (a != 3'd0);
    if (v && !stall && !flush && !rst) begin
      q1.push_back(x);
      q3.push_back(x);
    end
  endtask

  task automatic issue(input logic v, input logic w, input logic [2:0] a, input logic [15:0] d);
    present(v, w, a, d);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_q();
    q1.delete();
    q3.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; stall = 1'b0; flush = 1'b0;
    aluout_in = '0; waddr_in = '0; raddr1 = 3'd5; raddr2 = 3'd0;
    idle(2);
    rst = 1'b0;

    // Reset state and pass-through
    present(1'b1, 1'b1, 3'd5, 16'h1234);
    #1;
    chk("rst_d1_aluout", 32'(ao1), 0);
    chk("rst_d1_waddr", 32'(wa1), 0);
    chk("rst_d1_valid", 32'(vo1), 0);
    chk("rst_d1_wb_en", 32'(wb1), 0);
    chk("rst_d1_hit1", 32'(fh1a), 0);
    chk("rst_d1_fwd1", 32'(fd1a), 0);
    chk("rst_d1_cnt", 32'(cnt1), 0);
    chk("rst_d3_valid", 32'(vo3), 0);
    chk("rst_d3_cnt", 32'(cnt3), 0);
    cyc();
    in_valid = 1'b0;
    chk("pt_d1_aluout", 32'(ao1), 32'h1234);
    chk("pt_d1_waddr", 32'(wa1), 5);
    chk("pt_d1_wb_en", 32'(wb1), 1);
    chk("pt_d3_hit1", 32'(fh3a), 1);
    chk("pt_d3_fwd1", 32'(fd3a), 32'h1234);
    cyc();
    chk("pt_d1_cnt", 32'(cnt1), 1);
    idle(3);
    chk("pt_d3_cnt", 32'(cnt3), 1);

    // Depth latency and in-flight forwarding
    raddr1 = 3'd2;
    issue(1'b1, 1'b1, 3'd1, 16'h11);
    issue(1'b1, 1'b1, 3'd2, 16'h22);
    chk("lat_d3_not_yet", 32'(vo3), 0);
    issue(1'b1, 1'b1, 3'd3, 16'h33);
    chk("lat_d3_valid", 32'(vo3), 1);
    chk("lat_d3_aluout", 32'(ao3), 32'h11);
    chk("lat_d3_hit1", 32'(fh3a), 1);
    chk("lat_d3_fwd1", 32'(fd3a), 32'h22);
    idle(4);
    chk("lat_d1_cnt", 32'(cnt1), 4);
    chk("lat_d3_cnt", 32'(cnt3), 4);

    // Youngest wins; flush without stall drops the same-cycle input
    raddr1 = 3'd4;
    issue(1'b1, 1'b1, 3'd4, 16'hAA);
    chk("yw_d3_fwd_aa", 32'(fd3a), 32'hAA);
    issue(1'b1, 1'b1, 3'd4, 16'hBB);
    chk("yw_d3_hit1", 32'(fh3a), 1);
    chk("yw_d3_fwd_bb", 32'(fd3a), 32'hBB);
    chk("yw_d1_fwd_bb", 32'(fd1a), 32'hBB);
    flush = 1'b1;
    present(1'b1, 1'b1, 3'd4, 16'hCC);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    clear_q();
    chk("fl_d3_hit1", 32'(fh3a), 0);
    chk("fl_d3_fwd1", 32'(fd3a), 0);
    chk("fl_d1_valid", 32'(vo1), 0);
    chk("fl_d1_cnt", 32'(cnt1), 6);
    chk("fl_d3_cnt", 32'(cnt3), 4);

    // Stall holds an effective entry at the last stage
    raddr1 = 3'd6;
    issue(1'b1, 1'b1, 3'd6, 16'h66);
    idle(2);
    chk("st_d3_wb_pre", 32'(wb3), 1);
    stall = 1'b1;
    #1;
    chk("st_d3_wb_gated", 32'(wb3), 0);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, 3'd7, 16'h77);
      chk("st_d3_valid", 32'(vo3), 1);
      chk("st_d3_aluout", 32'(ao3), 32'h66);
      chk("st_d3_wb_en", 32'(wb3), 0);
      chk("st_d3_cnt", 32'(cnt3), 4);
      chk("st_d3_fwd1", 32'(fd3a), 32'h66);
    end
    stall = 1'b0;
    #1;
    chk("st_d3_wb_release", 32'(wb3), 1);
    cyc();
    chk("st_d3_wb_once", 32'(wb3), 0);
    chk("st_d3_cnt_after", 32'(cnt3), 5);
    chk("st_d1_cnt", 32'(cnt1), 7);

    // Flush together with stall
    raddr1 = 3'd2;
    raddr2 = 3'd3;
    issue(1'b1, 1'b1, 3'd1, 16'h01);
    issue(1'b1, 1'b1, 3'd2, 16'h02);
    issue(1'b1, 1'b1, 3'd3, 16'h03);
    flush = 1'b1;
    stall = 1'b1;
    #1;
    chk("fs_d3_wb_en", 32'(wb3), 0);
    chk("fs_d1_wb_en", 32'(wb1), 0);
    cyc();
    flush = 1'b0;
    stall = 1'b0;
    clear_q();
    chk("fs_d3_valid", 32'(vo3), 0);
    chk("fs_d1_valid", 32'(vo1), 0);
    chk("fs_d3_hit1", 32'(fh3a), 0);
    chk("fs_d3_hit2", 32'(fh3b), 0);
    chk("fs_d1_hit2", 32'(fh1b), 0);
    idle(3);
    chk("fs_d1_cnt", 32'(cnt1), 9);
    chk("fs_d3_cnt", 32'(cnt3), 5);

    // Zero register
    raddr1 = 3'd0;
    issue(1'b1, 1'b1, 3'd0, 16'hFFFF);
    chk("zr_d1_valid", 32'(vo1), 1);
    chk("zr_d1_wb_en", 32'(wb1), 0);
    chk("zr_d1_hit1", 32'(fh1a), 0);
    chk("zr_d3_hit1", 32'(fh3a), 0);
    idle(4);
    chk("zr_d1_cnt", 32'(cnt1), 9);
    chk("zr_d3_cnt", 32'(cnt3), 5);

    // Counter saturation
    for (int i = 0; i < 20; i++)
      issue(1'b1, 1'b1, 3'((i % 7) + 1), 16'(i + 16'h100));
    idle(4);
    chk("sat_d3_cnt", 32'(cnt3), 15);
    chk("sat_d1_cnt", 32'(cnt1), 29);

    // Reset mid-stream
    raddr1 = 3'd1;
    issue(1'b1, 1'b1, 3'd1, 16'h5A);
    issue(1'b1, 1'b1, 3'd2, 16'hA5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_q();
    chk("mr_d3_cnt", 32'(cnt3), 0);
    chk("mr_d1_cnt", 32'(cnt1), 0);
    chk("mr_d1_valid", 32'(vo1), 0);
    chk("mr_d3_hit1", 32'(fh3a), 0);
    for (int i = 0; i < 3; i++) begin
      chk("mr_d3_wb_en", 32'(wb3), 0);
      cyc();
    end
    chk("mr_d3_cnt_end", 32'(cnt3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
